// File: rtl/text_memory_arbiter_pkg.sv
// Shared constants and types for the text memory arbiter.
// Requester ids, text-region defaults, pipeline record and FSM encoding.
package text_memory_arbiter_pkg;

  localparam logic [31:0] TEXT_BEGIN_DEF     = 32'h0040_0000;
  localparam logic [31:0] TEXT_END_DEF       = 32'h0040_FFFF;
  localparam int          MEM_ADDR_WIDTH_DEF = 14;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic id;
    logic err;
  } pend_t;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/text_memory_arbiter_range_check.sv
// text_range_check: combinational inclusive [TEXT_BEGIN, TEXT_END] test
// on a 32-bit byte address, unsigned compare.
module text_range_check
  import text_memory_arbiter_pkg::*;
#(
  parameter logic [31:0] TEXT_BEGIN = TEXT_BEGIN_DEF,
  parameter logic [31:0] TEXT_END   = TEXT_END_DEF
) (
  input  logic [31:0] addr,
  output logic        in_range
);

  assign in_range = addr_in_range(addr, TEXT_BEGIN, TEXT_END);

endmodule

// File: rtl/text_memory_arbiter.sv
// text_memory_arbiter: shares the synchronous-read text memory between fetch (F)
// and data (D) readers. Define TEXT_ARB_ROUND_ROBIN_EN for round-robin on contention.
module text_memory_arbiter
  import text_memory_arbiter_pkg::*;
#(
  parameter logic [31:0] TEXT_BEGIN     = TEXT_BEGIN_DEF,
  parameter logic [31:0] TEXT_END       = TEXT_END_DEF,
  parameter int          MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      f_req_valid,
  output logic                      f_req_ready,
  input  logic [31:0]               f_address,
  input  logic                      f_flush,
  output logic                      f_resp_valid,
  output logic [31:0]               f_resp_data,
  output logic                      f_resp_error,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [31:0]               d_address,
  output logic                      d_resp_valid,
  output logic [31:0]               d_resp_data,
  output logic                      d_resp_error,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]               mem_q
);

  logic                      w_f_grant;
  logic                      w_d_grant;
  logic                      w_grant;
  logic [31:0]               w_grant_addr;
  logic                      w_in_range;
  logic                      w_pend_valid;
  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  pend_t                     r_pend;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
`ifdef TEXT_ARB_ROUND_ROBIN_EN
  logic                      r_last_grant;
`endif

  // Arbitration: ready is held low during reset so no grant can form.
  always_comb begin
    f_req_ready = 1'b0;
    d_req_ready = 1'b0;
    if (!reset_n) begin
      f_req_ready = 1'b0;
      d_req_ready = 1'b0;
    end else begin
`ifdef TEXT_ARB_ROUND_ROBIN_EN
      if (f_req_valid && d_req_valid) begin
        f_req_ready = (r_last_grant == REQ_D);
        d_req_ready = (r_last_grant == REQ_F);
      end else begin
        f_req_ready = f_req_valid;
        d_req_ready = d_req_valid;
      end
`else
      f_req_ready = f_req_valid;
      d_req_ready = d_req_valid && !f_req_valid;
`endif
    end
  end

  assign w_f_grant    = f_req_valid && f_req_ready;
  assign w_d_grant    = d_req_valid && d_req_ready;
  assign w_grant      = w_f_grant || w_d_grant;
  assign w_grant_addr = w_f_grant ? f_address : d_address;

  text_range_check #(
    .TEXT_BEGIN (TEXT_BEGIN),
    .TEXT_END   (TEXT_END)
  ) u_range_check (
    .addr     (w_grant_addr),
    .in_range (w_in_range)
  );

  // Next state of the pending-response pipeline.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = w_grant ? ST_BUSY : ST_IDLE;
      ST_BUSY: w_state_nxt = w_grant ? ST_BUSY : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pipeline register P and the held memory word address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_pend     <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend.id  <= w_f_grant ? REQ_F : REQ_D;
      r_pend.err <= w_grant && !w_in_range;
      if (w_grant) begin
        r_mem_addr <= w_grant_addr[MEM_ADDR_WIDTH+1:2];
      end else begin
        r_mem_addr <= r_mem_addr;
      end
    end
  end

`ifdef TEXT_ARB_ROUND_ROBIN_EN
  // Remember who won last so contention alternates; F wins first after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= REQ_D;
    end else if (w_f_grant) begin
      r_last_grant <= REQ_F;
    end else if (w_d_grant) begin
      r_last_grant <= REQ_D;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  assign w_pend_valid = (r_state == ST_BUSY);
  assign mem_address  = w_grant ? w_grant_addr[MEM_ADDR_WIDTH+1:2] : r_mem_addr;

  // Response steering; a flushed fetch response is fully suppressed.
  always_comb begin
    f_resp_valid = 1'b0;
    f_resp_data  = 32'h0;
    f_resp_error = 1'b0;
    d_resp_valid = 1'b0;
    d_resp_data  = 32'h0;
    d_resp_error = 1'b0;
    if (w_pend_valid && (r_pend.id == REQ_F) && !f_flush) begin
      f_resp_valid = 1'b1;
      f_resp_data  = r_pend.err ? 32'h0 : mem_q;
      f_resp_error = r_pend.err;
    end else if (w_pend_valid && (r_pend.id == REQ_D)) begin
      d_resp_valid = 1'b1;
      d_resp_data  = r_pend.err ? 32'h0 : mem_q;
      d_resp_error = r_pend.err;
    end else begin
      f_resp_valid = 1'b0;
      d_resp_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_text_memory_arbiter.sv
// Directed bench for text_memory_arbiter: a transaction-level model predicts
// every output each cycle, plus literal expectations for the listed scenarios.
module tb_text_memory_arbiter;

  logic        clock;
  logic        reset_n;
  logic        f_req_valid, f_req_ready, f_flush;
  logic [31:0] f_address;
  logic        f_resp_valid, f_resp_error;
  logic [31:0] f_resp_data;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_address;
  logic        d_resp_valid, d_resp_error;
  logic [31:0] d_resp_data;
  logic [13:0] mem_address;
  logic [31:0] mem_q;

  int n_chk  = 0;
  int n_fail = 0;

  text_memory_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_address(f_address),
    .f_flush(f_flush), .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
    .f_resp_error(f_resp_error),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_address(d_address),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_error(d_resp_error),
    .mem_address(mem_address), .mem_q(mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memw(input logic [13:0] w);
    return 32'hC0DE_0000 + ({18'd0, w} * 32'd3);
  endfunction

  // Text memory stand-in: synchronous read of the presented word address.
  always @(posedge clock) mem_q <= memw(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: one outstanding response, plus the last granted word and winner.
  logic        m_pv, m_id, m_err;
  logic [13:0] m_word;
  logic [13:0] m_last_word;
  logic        m_last_winner;

  function automatic logic [1:0] model_grant();
    logic gf, gd;
    gf = 1'b0; gd = 1'b0;
    if (reset_n === 1'b1) begin
`ifdef TEXT_ARB_ROUND_ROBIN_EN
      if (f_req_valid && d_req_valid) begin
        gf = (m_last_winner == 1'b1);
        gd = !gf;
      end else begin
        gf = f_req_valid;
        gd = d_req_valid;
      end
`else
      gf = f_req_valid;
      gd = d_req_valid && !f_req_valid;
`endif
    end
    return {gf, gd};
  endfunction

  function automatic logic out_of_text(input logic [31:0] a);
    return (a < 32'h0040_0000) || (a > 32'h0040_FFFF);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    logic [1:0]  g;
    logic [31:0] a;
    if (!reset_n) begin
      m_pv <= 1'b0; m_id <= 1'b0; m_err <= 1'b0; m_word <= 14'd0;
      m_last_word <= 14'd0; m_last_winner <= 1'b1;
    end else begin
      g = model_grant();
      a = g[1] ? f_address : d_address;
      m_pv <= |g;
      m_id <= g[0];
      m_err <= out_of_text(a);
      m_word <= a[15:2];
      if (|g) begin
        m_last_word   <= a[15:2];
        m_last_winner <= g[0];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    logic [1:0]  g;
    logic [31:0] a;
    logic        ef, ed;
    g  = model_grant();
    a  = g[1] ? f_address : d_address;
    ef = m_pv && (m_id == 1'b0) && !f_flush;
    ed = m_pv && (m_id == 1'b1);
    chk("f_req_ready", {31'd0, f_req_ready}, {31'd0, g[1]});
    chk("d_req_ready", {31'd0, d_req_ready}, {31'd0, g[0]});
    chk("mem_address", {18'd0, mem_address}, {18'd0, (|g) ? a[15:2] : m_last_word});
    chk("f_resp_valid", {31'd0, f_resp_valid}, {31'd0, ef});
    chk("f_resp_data", f_resp_data, (ef && !m_err) ? memw(m_word) : 32'h0);
    chk("f_resp_error", {31'd0, f_resp_error}, {31'd0, ef && m_err});
    chk("d_resp_valid", {31'd0, d_resp_valid}, {31'd0, ed});
    chk("d_resp_data", d_resp_data, (ed && !m_err) ? memw(m_word) : 32'h0);
    chk("d_resp_error", {31'd0, d_resp_error}, {31'd0, ed && m_err});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    f_req_valid = 1'b0; d_req_valid = 1'b0; f_flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; idle(); f_address = 32'h0; d_address = 32'h0;
    @(negedge clock);
    chk("reset_mem_address", {18'd0, mem_address}, 32'd0);
    chk("reset_f_ready", {31'd0, f_req_ready}, 32'd0);
    step(); step();
    reset_n = 1'b1;

    // 1. F only
    f_req_valid = 1'b1; f_address = 32'h0040_0010;
    @(negedge clock);
    chk("t1_mem_address", {18'd0, mem_address}, 32'd4);
    step(); idle();
    @(negedge clock);
    chk("t1_f_resp_valid", {31'd0, f_resp_valid}, 32'd1);
    chk("t1_f_resp_data", f_resp_data, 32'hC0DE_000C);
    chk("t1_f_resp_error", {31'd0, f_resp_error}, 32'd0);
    step();

    // 2. Contention under fixed priority
    f_address = 32'h0040_0100; d_address = 32'h0040_0200;
    for (int i = 0; i < 3; i++) begin
      f_req_valid = 1'b1; d_req_valid = 1'b1;
      @(negedge clock);
`ifndef TEXT_ARB_ROUND_ROBIN_EN
      chk("t2_d_req_ready", {31'd0, d_req_ready}, 32'd0);
      chk("t2_f_req_ready", {31'd0, f_req_ready}, 32'd1);
`endif
      step();
    end
    idle(); step();

    // 3. Range errors and top-of-range boundary
    d_req_valid = 1'b1; d_address = 32'h0041_0000;
    step(); idle();
    @(negedge clock);
    chk("t3_hi_valid", {31'd0, d_resp_valid}, 32'd1);
    chk("t3_hi_data", d_resp_data, 32'h0);
    chk("t3_hi_error", {31'd0, d_resp_error}, 32'd1);
    d_req_valid = 1'b1; d_address = 32'h003F_FFFC;
    step(); idle();
    @(negedge clock);
    chk("t3_lo_error", {31'd0, d_resp_error}, 32'd1);
    d_req_valid = 1'b1; d_address = 32'h0040_FFFC;
    step(); idle();
    @(negedge clock);
    chk("t3_edge_data", d_resp_data, 32'hC0DE_BFFD);
    chk("t3_edge_error", {31'd0, d_resp_error}, 32'd0);
    step();

    // 4. Flush colliding with a new fetch grant
    f_req_valid = 1'b1; f_address = 32'h0040_0020;
    step();
    f_flush = 1'b1; f_address = 32'h0040_0024;
    @(negedge clock);
    chk("t4_flushed", {31'd0, f_resp_valid}, 32'd0);
    step(); idle();
    @(negedge clock);
    chk("t4_new_valid", {31'd0, f_resp_valid}, 32'd1);
    chk("t4_new_data", f_resp_data, 32'hC0DE_001B);
    step();

    // 5. Reset asserted mid-cycle with a response pending
    f_req_valid = 1'b1; f_address = 32'h0040_0030;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_f_resp_valid", {31'd0, f_resp_valid}, 32'd0);
    chk("t5_f_resp_data", f_resp_data, 32'h0);
    chk("t5_mem_address", {18'd0, mem_address}, 32'd0);
    chk("t5_f_req_ready", {31'd0, f_req_ready}, 32'd0);
    step(); idle();
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_after_f", {31'd0, f_resp_valid}, 32'd0);
    chk("t5_after_d", {31'd0, d_resp_valid}, 32'd0);
    step();

    // 6. Back-to-back D grants
    for (int i = 0; i < 3; i++) begin
      d_req_valid = 1'b1; d_address = 32'h0040_0000 + 32'(i * 4);
      step();
      if (i == 2) idle();
      @(negedge clock);
      chk("t6_d_valid", {31'd0, d_resp_valid}, 32'd1);
      chk("t6_d_data", d_resp_data, 32'hC0DE_0000 + 32'(i * 3));
    end
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
